// File: rtl/gpio_keypad_scan_if.sv
// Key event stream from the keypad scanner to its consumer.
// valid/ready: the producer holds valid, code and press steady until the cycle
// in which valid && ready are both 1 at a clock edge; that edge transfers one event.
interface gpio_keypad_scan_if #(
  parameter int CODE_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_press;

  modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);
endinterface

// File: rtl/gpio_keypad_scan.sv
// Column-scanning keypad controller: per-key debounce and a small event FIFO
// reporting press/release transitions with a sticky overflow flag.
module gpio_keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic [COLS-1:0]        key_col,
  input  logic [ROWS-1:0]        key_row,
  output logic [ROWS*COLS-1:0]   key_state,
  gpio_keypad_scan_if.master     evt,
  output logic                   overflow,
  input  logic                   ovf_clr
);
  localparam int NKEYS   = ROWS * COLS;
  localparam int CODE_W  = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W   = 4;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;

  // Synchronizer flops hold the inverted row level, so 1 = key closed.
  logic [ROWS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cnt_q [NKEYS];
  logic [CNT_W-1:0]  cnt_d [NKEYS];
  logic [NKEYS-1:0]  state_q, state_d;
  logic [CODE_W-1:0] code_mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] code_mem_d [FIFO_DEPTH];
  logic              press_mem_q [FIFO_DEPTH];
  logic              press_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              push, push_press, pop, wr_en, drop, empty, full;
  logic [CODE_W-1:0] push_code;

  always_comb begin
    sync1_d = ~key_row;
    sync2_d = sync1_q;
    slot_d  = (slot_q == SLOT_W'(SCAN_DIV - 1)) ? '0 : slot_q + 1'b1;
    col_d   = col_q;
    if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
      col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      key_col[c] = (col_q != COL_W'(c));
    end
  end

  // The last ROWS slots of each column visit examine one row apiece.
  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    push       = 1'b0;
    push_code  = '0;
    push_press = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (slot_q == SLOT_W'(SCAN_DIV - ROWS + r) && col_q == COL_W'(c)) begin
          if (sync2_q[r] == state_q[r*COLS+c]) begin
            cnt_d[r*COLS+c] = '0;
          end else if (cnt_q[r*COLS+c] == CNT_W'(DEBOUNCE - 1)) begin
            state_d[r*COLS+c] = ~state_q[r*COLS+c];
            cnt_d[r*COLS+c]   = '0;
            push              = 1'b1;
            push_code         = CODE_W'(r*COLS + c);
            push_press        = ~state_q[r*COLS+c];
          end else begin
            cnt_d[r*COLS+c] = cnt_q[r*COLS+c] + 1'b1;
          end
        end
      end
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FCNT_W'(FIFO_DEPTH));
    pop         = !empty && evt.evt_ready;
    wr_en       = push && (!full || pop);
    drop        = push && full && !pop;
    code_mem_d  = code_mem_q;
    press_mem_d = press_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_en) begin
      code_mem_d[wr_ptr_q]  = push_code;
      press_mem_d[wr_ptr_q] = push_press;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      slot_q      <= '0;
      col_q       <= '0;
      cnt_q       <= '{default: '0};
      state_q     <= '0;
      code_mem_q  <= '{default: '0};
      press_mem_q <= '{default: 1'b0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      slot_q      <= slot_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      code_mem_q  <= code_mem_d;
      press_mem_q <= press_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign key_state     = state_q;
  assign overflow      = ovf_q;
  assign evt.evt_valid = !empty;
  assign evt.evt_code  = empty ? '0 : code_mem_q[rd_ptr_q];
  assign evt.evt_press = empty ? 1'b0 : press_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_gpio_keypad_scan.sv
// Bench for gpio_keypad_scan: a time-based keypad/debounce/queue reference model
// checked every cycle, plus directed scenarios and randomized key activity.
module tb_gpio_keypad_scan;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int NK = ROWS * COLS, CW = 4, W = CW + 1;

  logic            clk = 1'b0;
  logic            resetn;
  logic [COLS-1:0] key_col;
  logic [ROWS-1:0] key_row;
  logic [NK-1:0]   key_state;
  logic            overflow;
  logic            ovf_clr;
  logic [NK-1:0]   phys;

  gpio_keypad_scan_if #(.CODE_W(CW)) evt_if ();

  gpio_keypad_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .key_col(key_col), .key_row(key_row),
    .key_state(key_state), .evt(evt_if.master), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      key_row[r] = ~|(phys[r*COLS +: COLS] & ~key_col);
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time since reset gives slot/column; row levels are seen two
  // cycles late; each key keeps a disagreement count; events go to exp_q.
  int            m_slot, m_col;
  int            m_cnt [NK];
  logic [NK-1:0] m_state;
  logic [W-1:0]  exp_q [$];
  logic          m_ovf;
  logic          m_init = 1'b0;
  logic          m_rst_seen;
  logic [ROWS-1:0] h1, h2;

  always @(negedge clk) begin
    logic [COLS-1:0] exp_col;
    logic [ROWS-1:0] cur;
    logic [W-1:0]    ev;
    logic            pop, push, drop, full_before;
    int              r, k;
    if (m_init) begin
      exp_col = ~(4'b0001 << m_col);
      check_eq("key_col", key_col, exp_col);
      check_eq("key_state", key_state, m_state);
      check_eq("evt_valid", evt_if.evt_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check_eq("evt_head", {evt_if.evt_code, evt_if.evt_press}, exp_q[0]);
      else if (m_rst_seen) check_eq("evt_head_rst", {evt_if.evt_code, evt_if.evt_press}, 0);
      check_eq("overflow", overflow, m_ovf);
    end
    if (resetn === 1'b0) begin
      m_slot = 0; m_col = 0; m_state = '0; m_ovf = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      exp_q.delete();
      h1 = '0; h2 = '0;
      m_init = 1'b1; m_rst_seen = 1'b1;
    end else if (m_init) begin
      m_rst_seen = 1'b0;
      for (int rr = 0; rr < ROWS; rr++) cur[rr] = phys[rr*COLS + m_col];
      pop = (exp_q.size() != 0) && evt_if.evt_ready;
      push = 1'b0; drop = 1'b0; ev = '0;
      if (m_slot >= SCAN_DIV - ROWS) begin
        r = m_slot - (SCAN_DIV - ROWS);
        k = r * COLS + m_col;
        if (h2[r] == m_state[k]) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] == DEBOUNCE) begin
            m_state[k] = ~m_state[k];
            m_cnt[k] = 0;
            push = 1'b1;
            ev = {CW'(k), m_state[k]};
          end
        end
      end
      full_before = (exp_q.size() == FIFO_DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (!full_before || pop) exp_q.push_back(ev);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_slot++;
      if (m_slot == SCAN_DIV) begin
        m_slot = 0;
        m_col = (m_col + 1) % COLS;
      end
      h2 = h1;
      h1 = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_col_start(input logic [COLS-1:0] pat);
    int n;
    n = 0;
    while (key_col === pat && n < 100) begin tick(1); n++; end
    while (key_col !== pat && n < 200) begin tick(1); n++; end
    check_eq("wait_col", key_col, pat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int codes [4];
    int n, k, dur, mode;
    logic found;
    resetn = 1'b0; phys = '0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
    tick(2);
    check_eq("rst_key_col", key_col, 4'b1110);
    check_eq("rst_key_state", key_state, 0);
    check_eq("rst_valid", evt_if.evt_valid, 0);
    check_eq("rst_overflow", overflow, 0);
    resetn = 1'b1;

    // Single press and release of key 9 (row 2, column 1).
    phys[9] = 1'b1;
    tick(140);
    check_eq("press_state9", key_state[9], 1);
    check_eq("press_valid", evt_if.evt_valid, 1);
    check_eq("press_code", evt_if.evt_code, 9);
    check_eq("press_type", evt_if.evt_press, 1);
    evt_if.evt_ready = 1'b1; tick(1); evt_if.evt_ready = 1'b0;
    phys[9] = 1'b0;
    tick(140);
    check_eq("release_state9", key_state[9], 0);
    check_eq("release_code", evt_if.evt_code, 9);
    check_eq("release_type", evt_if.evt_press, 0);
    evt_if.evt_ready = 1'b1; tick(2); evt_if.evt_ready = 1'b0;

    // Bounce: closed for exactly two column-1 visits.
    wait_col_start(4'b1101);
    phys[9] = 1'b1;
    wait_col_start(4'b1011);
    wait_col_start(4'b1101);
    wait_col_start(4'b1011);
    phys[9] = 1'b0;
    tick(140);
    check_eq("bounce_state9", key_state[9], 0);
    check_eq("bounce_valid", evt_if.evt_valid, 0);

    // Overflow: five presses with no consumer.
    codes = '{0, 5, 10, 15};
    for (int i = 0; i < 4; i++) begin phys[codes[i]] = 1'b1; tick(140); end
    phys[3] = 1'b1; tick(140);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_state3", key_state[3], 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check_eq("ovf_clear", overflow, 0);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_drain_code", evt_if.evt_code, codes[i]);
      tick(1);
    end
    check_eq("ovf_drained", evt_if.evt_valid, 0);
    phys = '0; tick(150); evt_if.evt_ready = 1'b0;

    // Full FIFO with a pop in the same cycle as the fifth push.
    for (int i = 0; i < 4; i++) begin phys[codes[i]] = 1'b1; tick(140); end
    phys[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_col == 3 && m_slot == SCAN_DIV - ROWS && m_cnt[3] == DEBOUNCE - 1 && !m_state[3]) begin
        evt_if.evt_ready = 1'b1; tick(1); evt_if.evt_ready = 1'b0;
        found = 1'b1;
      end else tick(1);
    end
    check_eq("syncpop_found", found, 1);
    check_eq("syncpop_ovf", overflow, 0);
    check_eq("syncpop_head", evt_if.evt_code, 5);
    evt_if.evt_ready = 1'b1;
    n = 0;
    while (evt_if.evt_valid === 1'b1 && n < 10) begin tick(1); n++; end
    check_eq("syncpop_count", n, 4);
    phys = '0; tick(150); evt_if.evt_ready = 1'b0;

    // Reset while two events are queued and the keys remain held.
    phys[0] = 1'b1; phys[5] = 1'b1; tick(140);
    check_eq("midrst_queued", evt_if.evt_valid, 1);
    resetn = 1'b0; tick(1); resetn = 1'b1;
    check_eq("midrst_valid", evt_if.evt_valid, 0);
    check_eq("midrst_state", key_state, 0);
    evt_if.evt_ready = 1'b1;
    tick(60);
    check_eq("midrst_early", key_state, 0);
    tick(80);
    check_eq("midrst_repress", key_state, 16'h0021);
    phys = '0; tick(150);

    // Randomized key activity, consumer stalls, clears and resets.
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, NK - 1);
      dur = $urandom_range(20, 130);
      mode = $urandom_range(0, 2);
      phys[k] = ~phys[k];
      if ($urandom_range(0, 9) == 0) begin resetn = 1'b0; tick(1); resetn = 1'b1; end
      for (int c = 0; c < dur; c++) begin
        evt_if.evt_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        ovf_clr = ($urandom_range(0, 25) == 0);
        tick(1);
      end
      ovf_clr = 1'b0;
    end
    phys = '0; evt_if.evt_ready = 1'b1; tick(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/gpio_keypad_scan.md
GPIO_KEYPAD_SCAN -- requirements
Module: gpio_keypad_scan

Interface
REQ-001 Parameter ROWS, default 4, number of keypad row inputs (1..8).
REQ-002 Parameter COLS, default 4, number of keypad column outputs (1..8).
REQ-003 Parameter SCAN_DIV, default 50000, clock cycles per column slot; SHALL be at least ROWS+3.
REQ-004 Parameter DEBOUNCE, default 4, consecutive disagreeing samples needed to flip a key state (1..15).
REQ-005 Parameter FIFO_DEPTH, default 4, event queue depth (power of two, at least 2).
REQ-006 Derived widths: CODE_W = clog2(ROWS*COLS), minimum 1.
REQ-007 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 Port resetn, input, 1: reset is synchronous and active-low.
REQ-009 Port key_col, output, COLS: column drive, active-low, one-hot-zero.
REQ-010 Port key_row, input, ROWS: row sense, active-low (0 = key closed on the driven column), asynchronous.
REQ-011 Port key_state, output, ROWS*COLS: debounced state, bit (r*COLS+c), 1 = pressed.
REQ-012 Port evt_valid, output, 1: event available at the FIFO head.
REQ-013 Port evt_ready, input, 1: consumer accepts the head event.
REQ-014 Port evt_code, output, CODE_W: head event key index r*COLS+c.
REQ-015 Port evt_press, output, 1: head event type; 1 = press, 0 = release.
REQ-016 Port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-017 Port ovf_clr, input, 1: single-cycle pulse that clears overflow.

Function
REQ-018 key_row SHALL pass through a 2-flop synchronizer before any use.
REQ-019 Slot counter SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-020 The column index SHALL advance on each wrap, going 0..COLS-1 and then back to 0.
REQ-021 key_col SHALL drive 0 on the active column bit and 1 on all other bits.
REQ-022 Row r of the active column SHALL be sampled (inverted synchronized key_row[r]) when the slot count equals SCAN_DIV-ROWS+r, so at most one key is evaluated per cycle.
REQ-023 Each key SHALL have a debounce counter; a sample equal to key_state clears it.
REQ-024 A sample that differs from key_state SHALL increment the counter.
REQ-025 When the counter reaches DEBOUNCE, key_state SHALL flip, the counter SHALL clear, and one event SHALL be pushed: code = key index, press = new state.
REQ-026 Minimum latency from a stable level change to key_state change is DEBOUNCE column visits, i.e. (DEBOUNCE-1)*COLS*SCAN_DIV plus at most one scan period plus 3 cycles.
REQ-027 FIFO: evt_valid=1 whenever it is non-empty; evt_code and evt_press show the oldest entry.
REQ-028 An event pushed into an empty FIFO SHALL make evt_valid=1 on the next cycle.
REQ-029 A pop occurs when evt_valid and evt_ready are both 1 on a clock edge.
REQ-030 evt_code and evt_press SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-031 Push while full with no pop: the event SHALL be dropped, overflow set to 1, and key_state still flipped.
REQ-032 Push while full with a simultaneous pop: both SHALL occur, with no drop and no overflow.
REQ-033 Push and pop on a FIFO holding one entry SHALL leave the count at 1 and the new event at the head next cycle.
REQ-034 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be a separate 0..FIFO_DEPTH counter.
REQ-035 If ovf_clr and an overflow-setting drop occur in the same cycle, overflow SHALL end at 1 (set wins).
REQ-036 evt_ready while evt_valid=0 SHALL have no effect.

Reset
REQ-037 When resetn=0 at a clock edge, the following SHALL reset on the next cycle: slot counter=0, column=0, key_col={all 1 except bit0=0}.
REQ-038 Also on that edge: synchronizers=0 (released), all debounce counters=0, key_state=0, FIFO empty (evt_valid=0), overflow=0.
REQ-039 evt_code and evt_press SHALL be 0 during reset.
REQ-040 Reset mid-scan or mid-debounce SHALL discard all pending events, with no release events generated for previously pressed keys.

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-041 Reset: hold resetn=0 for 2 cycles -> key_col=4'b1110, key_state=0, evt_valid=0, overflow=0; after release, key_col steps 1101, 1011, 0111, 1110 every 8 cycles.
REQ-042 Press: key_row[2]=0 only while key_col[1]=0, held -> after 3 column-1 visits key_state[9]=1 and evt_valid=1, evt_code=9, evt_press=1; releasing it later gives evt_code=9, evt_press=0.
REQ-043 Bounce: row2/col1 closed for 2 visits then open -> no event; key_state[9] stays 0.
REQ-044 Overflow: evt_ready=0, keys 0, 5, 10, 15, 3 pressed in turn -> 4 events queued in that order, overflow=1, key_state[3]=1; an ovf_clr pulse sets overflow=0; draining yields codes 0, 5, 10, 15.
REQ-045 Full with simultaneous pop: FIFO full, evt_ready=1 in the same cycle as a 5th push -> overflow stays 0 and the count stays 4.
REQ-046 Reset mid-operation: 2 events queued, resetn=0 for 1 cycle -> evt_valid=0, key_state=0; a key still held re-reports press only after 3 fresh visits.
